// File: rtl/tt_bist_pkg.sv
// Shared types for the pin self-test: FSM states, pattern modes, ui_in and
// status bit positions, and the pattern step function.
package tt_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] MODE_CONST = 2'b00;
  localparam logic [1:0] MODE_INC   = 2'b01;
  localparam logic [1:0] MODE_LFSR  = 2'b10;
  localparam logic [1:0] MODE_WALK  = 2'b11;

  // ui_in control bits
  localparam int UI_START    = 2;
  localparam int UI_ABORT    = 3;
  localparam int UI_DISP     = 4;
  localparam int UI_SHOW_EXP = 5;
  localparam int UI_SHOW_RCV = 6;

  // status byte bit positions on uo_out
  localparam int STB_DONE = 7;
  localparam int STB_PASS = 6;
  localparam int STB_BUSY = 5;
  localparam int STB_SAT  = 4;

  // One step of the selected pattern sequence.
  function automatic logic [7:0] pat_next(input logic [1:0] mode,
                                          input logic [7:0] p,
                                          input logic [7:0] taps);
    case (mode)
      MODE_INC:  return p + 8'h01;
      MODE_LFSR: return p[0] ? ((p >> 1) ^ taps) : (p >> 1);
      MODE_WALK: return {p[6:0], p[7]};
      default:   return p;
    endcase
  endfunction

endpackage

// File: rtl/tt_pin_bist_if.sv
// Pin bundle of the tt_um user slot as seen by the self-test block.
interface tt_pin_bist_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_bist_patgen.sv
// Pattern generator: loads SEED (0 becomes 8'h01 for the LFSR, which would
// otherwise lock up) and steps the selected sequence once per advance.
module tt_bist_patgen
  import tt_bist_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01,
  parameter logic [7:0] TAPS = 8'hB8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       load_i,
  input  logic       adv_i,
  input  logic [1:0] mode_i,
  output logic [7:0] pat_o
);

  logic [7:0] pat_q, pat_d, seed_v;

  // next pattern: load wins over advance
  always_comb begin
    seed_v = ((mode_i == MODE_LFSR) && (SEED == 8'h00)) ? 8'h01 : SEED;
    pat_d  = pat_q;
    if (load_i)     pat_d = seed_v;
    else if (adv_i) pat_d = pat_next(mode_i, pat_q, TAPS);
  end

  // pattern register, frozen while the slot is deselected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pat_q <= 8'h00;
    else if (en_i) pat_q <= pat_d;
  end

  assign pat_o = pat_q;

endmodule

// File: rtl/tt_pin_bist.sv
// Pin loopback self-test for the tt_um slot: drives a pattern on uio_out,
// checks uio_in against the pattern delayed LAT cycles, counts mismatches.
// Optional macro TT_BIST_FIRST_FAIL_EN adds first-mismatch capture.
module tt_pin_bist
  import tt_bist_pkg::*;
#(
  parameter int         LEN_W = 4,
  parameter int         LAT   = 2,
  parameter int         ERR_W = 8,
  parameter logic [7:0] SEED  = 8'h01,
  parameter logic [7:0] TAPS  = 8'hB8
) (
  input logic          clk,
  input logic          rst_n,
  tt_pin_bist_if.slave bus
);

  localparam int NBEAT  = 2 ** LEN_W;
  localparam int RUNLEN = NBEAT + LAT;
  localparam int CNT_W  = $clog2(RUNLEN + 1);

  state_e               state_q, state_d;
  logic                 start_q, start_prev_q, start_rise, abort, ena;
  logic [1:0]           mode_q, mode_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 pass_q, pass_d;
  logic [LAT-1:0][7:0]  dly_q, dly_d;
  logic [7:0]           pat, uo_q, uo_d, oe_q, oe_d, err_disp;
  logic                 cmp_en, miss;
  logic                 unused_ui;

  assign ena        = bus.ena;
  assign abort      = bus.ui_in[UI_ABORT];
  assign start_rise = start_q & ~start_prev_q;
  assign unused_ui  = ^bus.ui_in[7:5];

  // compare window opens once the first driven beat has looped back
  assign cmp_en = (state_q == ST_RUN) && (cnt_q >= CNT_W'(LAT));
  assign miss   = cmp_en && (bus.uio_in != dly_q[LAT-1]);

  tt_bist_patgen #(.SEED(SEED), .TAPS(TAPS)) u_patgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (ena),
    .load_i (state_q == ST_ARM),
    .adv_i  (state_q == ST_RUN),
    .mode_i (mode_d),
    .pat_o  (pat)
  );

  // FSM next state; abort overrides everything, including start
  always_comb begin
    state_d = state_q;
    if (abort) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE: if (start_rise) state_d = ST_ARM;
        ST_ARM:  state_d = ST_RUN;
        ST_RUN:  if (cnt_q == CNT_W'(RUNLEN - 1)) state_d = ST_DONE;
        ST_DONE: if (start_rise) state_d = ST_ARM;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // run datapath: ARM clears, RUN shifts the delay line and counts misses
  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    pass_d = pass_q;
    dly_d  = dly_q;
    if (state_q == ST_ARM) begin
      mode_d = bus.ui_in[1:0];
      cnt_d  = '0;
      err_d  = '0;
      pass_d = 1'b0;
      dly_d  = '0;
    end else if (state_q == ST_RUN) begin
      cnt_d    = cnt_q + 1'b1;
      dly_d[0] = pat;
      for (int i = 1; i < LAT; i++) dly_d[i] = dly_q[i-1];
      if (miss && (err_q != '1)) err_d = err_q + 1'b1;
    end
    if ((state_q == ST_RUN) && (state_d == ST_DONE)) pass_d = (err_d == '0);
  end

  if (ERR_W >= 8) begin : g_err_trunc
    assign err_disp = err_d[7:0];
  end else begin : g_err_ext
    assign err_disp = {{(8 - ERR_W){1'b0}}, err_d};
  end

`ifdef TT_BIST_FIRST_FAIL_EN
  logic       ff_vld_q, ff_vld_d;
  logic [7:0] ff_exp_q, ff_exp_d, ff_rcv_q, ff_rcv_d;

  // keep only the first mismatch of a run
  always_comb begin
    ff_vld_d = ff_vld_q;
    ff_exp_d = ff_exp_q;
    ff_rcv_d = ff_rcv_q;
    if (state_q == ST_ARM) begin
      ff_vld_d = 1'b0;
      ff_exp_d = 8'h00;
      ff_rcv_d = 8'h00;
    end else if (miss && !ff_vld_q) begin
      ff_vld_d = 1'b1;
      ff_exp_d = dly_q[LAT-1];
      ff_rcv_d = bus.uio_in;
    end
  end

  // first-mismatch capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_vld_q <= 1'b0;
      ff_exp_q <= 8'h00;
      ff_rcv_q <= 8'h00;
    end else if (ena) begin
      ff_vld_q <= ff_vld_d;
      ff_exp_q <= ff_exp_d;
      ff_rcv_q <= ff_rcv_d;
    end
  end
`endif

  // output byte built from next-state values so it lines up with state_q
  always_comb begin
    uo_d = {state_d == ST_DONE, pass_d, (state_d == ST_ARM) || (state_d == ST_RUN),
            err_d == '1, mode_d, state_d};
    if (bus.ui_in[UI_DISP]) begin
      uo_d = err_disp;
`ifdef TT_BIST_FIRST_FAIL_EN
      if (bus.ui_in[UI_SHOW_RCV])      uo_d = ff_rcv_d;
      else if (bus.ui_in[UI_SHOW_EXP]) uo_d = ff_exp_d;
`endif
    end
    oe_d = (state_d == ST_RUN) ? 8'hFF : 8'h00;
  end

  // state registers; everything holds while the slot is deselected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      mode_q       <= MODE_CONST;
      cnt_q        <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      dly_q        <= '0;
      uo_q         <= 8'h00;
      oe_q         <= 8'h00;
    end else if (ena) begin
      state_q      <= state_d;
      start_q      <= bus.ui_in[UI_START];
      start_prev_q <= start_q;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      dly_q        <= dly_d;
      uo_q         <= uo_d;
      oe_q         <= oe_d;
    end
  end

  // deselected slot must release the bidirectional pins at once
  assign bus.uo_out  = uo_q;
  assign bus.uio_out = pat;
  assign bus.uio_oe  = ena ? oe_q : 8'h00;

endmodule
